// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int ARB_ADDR_W = 12;
    localparam int ARB_DATA_W = 32;

    // Instruction fetches are always full-word accesses.
    localparam logic [2:0] FETCH_FUNCT3 = 3'b010;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT,
        ARB_DONE
    } arb_state_e;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_e;

    // Command latched at grant time and presented to the memory macro.
    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic                  we;
        logic [ARB_DATA_W-1:0] wdata;
        logic [2:0]            funct3;
    } mem_cmd_t;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that times the fixed memory latency.
// expired_o is high whenever the count has reached zero.
module mem_lat_counter #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: load has priority, otherwise count down to zero and stop.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves cnt_d unassigned (which would infer a latch).
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of block ordering.
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port fixed-latency memory between instruction fetch (IF)
// and load/store (DM). DM wins arbitration unless IF has been starved for
// STARVE_MAX consecutive DM grants. Optional performance counters are built
// when the macro MEM_ARB_PERF_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ARB_ADDR_W,
    parameter int DATA_W     = ARB_DATA_W,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_valid_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [2:0]        dm_funct3_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_valid_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [2:0]        mem_funct3_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]       perf_if_cnt_o,
    output logic [31:0]       perf_dm_cnt_o,
    output logic [31:0]       perf_stall_cnt_o,
`endif
    output logic              stall_if_o,
    output logic              stall_mem_o
);

    localparam int CNT_W    = $clog2(MEM_LAT + 1);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    arb_state_e          state_q, state_d;
    owner_e              owner_q, owner_d;
    mem_cmd_t            cmd_q, cmd_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic                flush_q, flush_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                if_valid_q, if_valid_d;
    logic                dm_valid_q, dm_valid_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
    logic                grant_if, grant_dm;
    logic                cnt_load, cnt_expired;

    mem_lat_counter #(.W(CNT_W)) u_lat_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (cnt_load),
        .load_val_i (CNT_W'(MEM_LAT)),
        .en_i       (state_q == ARB_WAIT),
        .expired_o  (cnt_expired)
    );

    // Arbitration, transaction sequencing and response capture.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cmd_d      = cmd_q;
        mem_req_d  = 1'b0;
        mem_we_d   = 1'b0;
        flush_d    = flush_q;
        starve_d   = if_req_i ? starve_q : '0;
        if_valid_d = 1'b0;
        dm_valid_d = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        grant_if   = 1'b0;
        grant_dm   = 1'b0;
        cnt_load   = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                flush_d = 1'b0;
                if (dm_req_i && !(if_req_i && starve_q == STARVE_W'(STARVE_MAX))) begin
                    grant_dm = 1'b1;
                end else if (if_req_i) begin
                    grant_if = 1'b1;
                end

                if (grant_dm) begin
                    owner_d = OWN_DM;
                    cmd_d   = '{addr: dm_addr_i, we: dm_we_i, wdata: dm_wdata_i, funct3: dm_funct3_i};
                    if (if_req_i && starve_q != STARVE_W'(STARVE_MAX)) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end else if (grant_if) begin
                    owner_d  = OWN_IF;
                    cmd_d    = '{addr: if_addr_i, we: 1'b0, wdata: '0, funct3: FETCH_FUNCT3};
                    starve_d = '0;
                end

                if (grant_dm || grant_if) begin
                    mem_req_d = 1'b1;
                    mem_we_d  = cmd_d.we;
                    cnt_load  = 1'b1;
                    state_d   = ARB_WAIT;
                end
            end

            ARB_WAIT: begin
                if (owner_q == OWN_IF && if_flush_i) begin
                    flush_d = 1'b1;
                end
                if (cnt_expired) begin
                    state_d = ARB_DONE;
                    if (owner_q == OWN_IF) begin
                        // A flushed fetch is dropped entirely.
                        if (!(flush_q || if_flush_i)) begin
                            if_valid_d = 1'b1;
                            if_rdata_d = mem_rdata_i;
                        end
                    end else begin
                        dm_valid_d = 1'b1;
                        dm_rdata_d = cmd_q.we ? '0 : mem_rdata_i;
                    end
                end
            end

            ARB_DONE: begin
                state_d = ARB_IDLE;
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWN_IF;
            cmd_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            flush_q    <= 1'b0;
            starve_q   <= '0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cmd_q      <= cmd_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            flush_q    <= flush_d;
            starve_q   <= starve_d;
            if_valid_q <= if_valid_d;
            dm_valid_q <= dm_valid_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = cmd_q.addr;
    assign mem_wdata_o  = cmd_q.wdata;
    assign mem_funct3_o = cmd_q.funct3;
    assign if_rdata_o   = if_rdata_q;
    assign dm_rdata_o   = dm_rdata_q;
    assign dm_valid_o   = dm_valid_q;
    // A flush arriving in the DONE cycle still suppresses the pulse.
    assign if_valid_o   = if_valid_q & ~if_flush_i;
    assign stall_if_o   = if_req_i & ~if_valid_o;
    assign stall_mem_o  = dm_req_i & ~dm_valid_o;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_q, perf_dm_q, perf_stall_q;

    // Saturating grant and stall-cycle counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_if_q    <= '0;
            perf_dm_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            if (grant_if && perf_if_q != '1) begin
                perf_if_q <= perf_if_q + 32'd1;
            end
            if (grant_dm && perf_dm_q != '1) begin
                perf_dm_q <= perf_dm_q + 32'd1;
            end
            if ((stall_if_o || stall_mem_o) && perf_stall_q != '1) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_if_cnt_o    = perf_if_q;
    assign perf_dm_cnt_o    = perf_dm_q;
    assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a cycle-indexed transaction model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_flush, dm_req, dm_we;
    logic [11:0] if_addr, dm_addr;
    logic [2:0]  dm_funct3;
    logic [31:0] dm_wdata, mem_rdata;
    logic [31:0] if_rdata, dm_rdata, mem_wdata;
    logic        if_valid, dm_valid, mem_req, mem_we, stall_if, stall_mem;
    logic [11:0] mem_addr;
    logic [2:0]  mem_funct3;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if, perf_dm, perf_stall;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .if_req_i     (if_req),
        .if_addr_i    (if_addr),
        .if_flush_i   (if_flush),
        .if_rdata_o   (if_rdata),
        .if_valid_o   (if_valid),
        .dm_req_i     (dm_req),
        .dm_we_i      (dm_we),
        .dm_funct3_i  (dm_funct3),
        .dm_addr_i    (dm_addr),
        .dm_wdata_i   (dm_wdata),
        .dm_rdata_o   (dm_rdata),
        .dm_valid_o   (dm_valid),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_funct3_o (mem_funct3),
        .mem_rdata_i  (mem_rdata),
`ifdef MEM_ARB_PERF_EN
        .perf_if_cnt_o    (perf_if),
        .perf_dm_cnt_o    (perf_dm),
        .perf_stall_cnt_o (perf_stall),
`endif
        .stall_if_o   (stall_if),
        .stall_mem_o  (stall_mem)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Read-only memory contents.
    function automatic logic [31:0] rom(input logic [11:0] a);
        if (a == 12'h010) return 32'h00500093;
        return 32'hC0DE0000 ^ {20'h0, a} ^ ({20'h0, a} << 20);
    endfunction

    // Memory macro: data valid exactly LAT cycles after the command, junk otherwise.
    int          rd_due = -1;
    logic [11:0] rd_addr = '0;
    always @(negedge clk) begin
        if (rst_n && mem_req) begin
            rd_due  = cyc + LAT;
            rd_addr = mem_addr;
        end
    end
    always @(posedge clk) begin
        #1;
        mem_rdata = (cyc == rd_due) ? rom(rd_addr) : (32'hBAD00000 | 32'(cyc));
    end

    // Transaction model: a grant at cycle g gives mem_req at g+1, the response
    // at g+2+LAT and a free port again at g+3+LAT.
    bit          m_act = 0, m_gif = 0, m_we = 0, m_fl = 0;
    int          m_g = 0, m_starve = 0, m_done = 0;
    logic [11:0] m_addr = '0;
    logic [31:0] m_wdata = '0, m_dm_rd = '0;
    logic [2:0]  m_f3 = '0;
    bit          e_mreq, e_ifv, e_dmv;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_act = 0; m_starve = 0; m_dm_rd = '0;
            check("rst mem_req", mem_req, 0);
            check("rst mem_addr", mem_addr, 0);
            check("rst if_valid", if_valid, 0);
            check("rst dm_valid", dm_valid, 0);
            check("rst dm_rdata", dm_rdata, 0);
        end else begin
            m_done = m_g + 2 + LAT;
            e_mreq = m_act && cyc == m_g + 1;
            e_ifv  = m_act && m_gif && cyc == m_done && !m_fl && !if_flush;
            e_dmv  = m_act && !m_gif && cyc == m_done;
            if (m_act && m_gif && cyc > m_g && cyc < m_done && if_flush) m_fl = 1;
            if (e_dmv) m_dm_rd = m_we ? 32'h0 : rom(m_addr);

            check("mem_req", mem_req, e_mreq);
            check("if_valid", if_valid, e_ifv);
            check("dm_valid", dm_valid, e_dmv);
            check("dm_rdata", dm_rdata, m_dm_rd);
            check("stall_if", stall_if, if_req & ~e_ifv);
            check("stall_mem", stall_mem, dm_req & ~e_dmv);
            if (e_ifv) check("if_rdata", if_rdata, rom(m_addr));
            if (e_mreq) begin
                check("mem_addr", mem_addr, m_addr);
                check("mem_funct3", mem_funct3, m_f3);
                check("mem_we", mem_we, m_we);
                if (m_we) check("mem_wdata", mem_wdata, m_wdata);
            end else begin
                check("mem_we idle", mem_we, 0);
            end

            if (m_act && cyc >= m_g + 3 + LAT) m_act = 0;
            if (!if_req) m_starve = 0;
            if (!m_act) begin
                if (dm_req && !(if_req && m_starve >= SMAX)) begin
                    m_act = 1; m_gif = 0; m_g = cyc; m_fl = 0;
                    m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata; m_f3 = dm_funct3;
                    if (if_req && m_starve < SMAX) m_starve++;
                end else if (if_req) begin
                    m_act = 1; m_gif = 1; m_g = cyc; m_fl = 0;
                    m_addr = if_addr; m_we = 0; m_f3 = 3'b010;
                    m_starve = 0;
                end
            end
        end
    end

    task automatic goto_neg(input int c);
        while (cyc < c) begin @(posedge clk); #1; end
        @(negedge clk);
    endtask

    task automatic goto_drive(input int c);
        while (cyc < c) begin @(posedge clk); #1; end
    endtask

    task automatic scen_conflict();
        int t;
        goto_drive(cyc + 1);
        t = cyc;
        if_req = 1; if_addr = 12'h040;
        dm_req = 1; dm_we = 0; dm_addr = 12'h100; dm_funct3 = 3'b010;
        goto_neg(t + 1);
        check("conflict dm mem_req", mem_req, 1);
        check("conflict dm addr", mem_addr, 12'h100);
        goto_neg(t + 4);
        check("conflict dm_valid", dm_valid, 1);
        check("conflict dm_rdata", dm_rdata, 32'hD0DE0100);
        goto_drive(t + 5);
        dm_req = 0;
        goto_neg(t + 6);
        check("conflict if mem_req", mem_req, 1);
        check("conflict if addr", mem_addr, 12'h040);
        goto_neg(t + 9);
        check("conflict if_valid", if_valid, 1);
        check("conflict if_rdata", if_rdata, 32'hC4DE0040);
        goto_drive(t + 10);
        if_req = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          t, n;
        logic [11:0] seq [6];

        rst_n = 0; if_req = 0; if_flush = 0; dm_req = 0; dm_we = 0;
        if_addr = '0; dm_addr = '0; dm_funct3 = '0; dm_wdata = '0;
        goto_drive(3);
        rst_n = 1;
        goto_drive(5);

        // Plain fetch.
        t = cyc;
        if_req = 1; if_addr = 12'h010;
        goto_neg(t);
        check("fetch stall_if@0", stall_if, 1);
        goto_neg(t + 1);
        check("fetch mem_req", mem_req, 1);
        check("fetch addr", mem_addr, 12'h010);
        check("fetch funct3", mem_funct3, 3'b010);
        goto_neg(t + 3);
        check("fetch stall_if@3", stall_if, 1);
        goto_neg(t + 4);
        check("fetch if_valid", if_valid, 1);
        check("fetch if_rdata", if_rdata, 32'h00500093);
        goto_drive(t + 5);
        if_req = 0;
        goto_drive(t + 7);

        // Simultaneous requests: DM first, then IF.
        scen_conflict();
        goto_drive(cyc + 2);

        // Store, with a flush pulse that must not affect it.
        t = cyc;
        dm_req = 1; dm_we = 1; dm_addr = 12'h0A4; dm_wdata = 32'hDEADBEEF; dm_funct3 = 3'b010;
        goto_neg(t + 1);
        check("store mem_we", mem_we, 1);
        check("store wdata", mem_wdata, 32'hDEADBEEF);
        check("store addr", mem_addr, 12'h0A4);
        goto_drive(t + 2);
        if_flush = 1;
        goto_neg(t + 4);
        check("store dm_valid", dm_valid, 1);
        check("store dm_rdata", dm_rdata, 0);
        goto_drive(t + 5);
        dm_req = 0; dm_we = 0; if_flush = 0;
        goto_drive(t + 7);

        // Starvation: both held, grant order DM x4, IF, DM.
        t = cyc;
        dm_req = 1; dm_addr = 12'h300; if_req = 1; if_addr = 12'h200;
        n = 0;
        for (int k = 0; k < 80 && n < 6; k++) begin
            @(negedge clk);
            if (mem_req) begin
                seq[n] = mem_addr;
                n++;
            end
        end
        check("starve grant count", n, 6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("starve grant %0d", k), seq[k], (k == 4) ? 12'h200 : 12'h300);
        end
        goto_drive(cyc + 1);
        dm_req = 0; if_req = 0;
        goto_drive(cyc + 8);

        // Flush in WAIT: no response, next fetch accepted.
        t = cyc;
        if_req = 1; if_addr = 12'h020;
        goto_drive(t + 2);
        if_flush = 1;
        goto_drive(t + 3);
        if_flush = 0;
        goto_drive(t + 4);
        if_req = 0;
        goto_neg(t + 4);
        check("flush no if_valid", if_valid, 0);
        goto_drive(t + 5);
        if_req = 1; if_addr = 12'h030;
        goto_neg(t + 6);
        check("flush next mem_req", mem_req, 1);
        check("flush next addr", mem_addr, 12'h030);
        goto_neg(t + 9);
        check("flush next if_valid", if_valid, 1);
        check("flush next if_rdata", if_rdata, 32'hC3DE0030);
        goto_drive(t + 10);
        if_req = 0;
        goto_drive(t + 12);

        // Flush in the DONE cycle.
        t = cyc;
        if_req = 1; if_addr = 12'h050;
        goto_drive(t + 4);
        if_flush = 1; if_req = 0;
        goto_neg(t + 4);
        check("late flush if_valid", if_valid, 0);
        goto_drive(t + 5);
        if_flush = 0;
        goto_drive(t + 7);

        // Reset in the middle of a load.
        t = cyc;
        dm_req = 1; dm_we = 0; dm_addr = 12'h140;
        goto_drive(t + 2);
        rst_n = 0; dm_req = 0;
        #1;
        check("reset mem_addr", mem_addr, 0);
        check("reset mem_req", mem_req, 0);
        check("reset dm_rdata", dm_rdata, 0);
        check("reset if_rdata", if_rdata, 0);
        check("reset dm_valid", dm_valid, 0);
        goto_drive(t + 4);
        rst_n = 1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("post-reset dm_valid", dm_valid, 0);
        end
        goto_drive(cyc + 1);

        // Conflict again from a clean reset, then the counters.
        t = cyc;
        scen_conflict();
`ifdef MEM_ARB_PERF_EN
        goto_neg(t + 12);
        check("perf_if_cnt", perf_if, 1);
        check("perf_dm_cnt", perf_dm, 1);
        check("perf_stall_cnt", perf_stall, 9);
`endif
        goto_drive(cyc + 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
